// File: rtl/regfile_pkg.sv
// Shared widths and the write-request record for the 4x16 register file and its write-port arbiter.
package regfile_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 2;
   localparam int NUM_REGS = 1 << ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/wr_slot.sv
// One-entry holding register for a pending register-file write.
// A fill on the same edge as a drain wins, so the slot can stream one write per cycle.
module wr_slot
   import regfile_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              fill,
   input  logic              drain,
   input  logic [ADDR_W-1:0] fill_addr,
   input  logic [DATA_W-1:0] fill_data,
   output logic              full,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   logic    full_q, full_d;
   wr_req_t req_q, req_d;

   always_comb begin
      full_d = full_q;
      req_d  = req_q;
      if (drain) begin
         full_d = 1'b0;
      end
      if (fill) begin
         full_d = 1'b1;
         req_d  = '{addr: fill_addr, data: fill_data};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         full_q <= 1'b0;
         req_q  <= '0;
      end else begin
         full_q <= full_d;
         req_q  <= req_d;
      end
   end

   assign full = full_q;
   assign addr = req_q.addr;
   assign data = req_q.data;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester arbiter for the single reg_file write port: req0 preferred, req1 protected by a starvation counter.
// Define REGFILE_ARB_FWD_EN to forward pending writes onto rd1/rd2; otherwise rd1/rd2 pass rd1_in/rd2_in through.
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int STARVE_MAX = 3
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic [ADDR_W-1:0] wr,
   output logic [DATA_W-1:0] wd,
   output logic              regwrite,
   input  logic [ADDR_W-1:0] rr1,
   input  logic [ADDR_W-1:0] rr2,
   input  logic [DATA_W-1:0] rd1_in,
   input  logic [DATA_W-1:0] rd2_in,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              busy
);

   localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [1:0]        valid_v, ready_v, fill_v, full_v, grant_v, keep_v;
   logic [ADDR_W-1:0] in_addr_a [2];
   logic [DATA_W-1:0] in_data_a [2];
   logic [ADDR_W-1:0] slot_addr_a [2];
   logic [DATA_W-1:0] slot_data_a [2];

   logic              age_q, age_d;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              regwrite_q, regwrite_d;
   logic [ADDR_W-1:0] wr_q, wr_d;
   logic [DATA_W-1:0] wd_q, wd_d;

   assign valid_v      = {req1_valid, req0_valid};
   assign in_addr_a[0] = req0_addr;
   assign in_addr_a[1] = req1_addr;
   assign in_data_a[0] = req0_data;
   assign in_data_a[1] = req1_data;
   assign req0_ready   = ready_v[0];
   assign req1_ready   = ready_v[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_slot
         // Ready counts a same-edge drain so a held valid streams every cycle.
         assign ready_v[gi] = !reset && (!full_v[gi] || grant_v[gi]);
         assign fill_v[gi]  = valid_v[gi] && ready_v[gi];
         assign keep_v[gi]  = full_v[gi] && !grant_v[gi];

         wr_slot u_slot (
            .clock     (clock),
            .reset     (reset),
            .fill      (fill_v[gi]),
            .drain     (grant_v[gi]),
            .fill_addr (in_addr_a[gi]),
            .fill_data (in_data_a[gi]),
            .full      (full_v[gi]),
            .addr      (slot_addr_a[gi]),
            .data      (slot_data_a[gi])
         );
      end
   endgenerate

   always_comb begin
      grant_v = 2'b00;
      if (full_v == 2'b11) begin
         // Same destination must drain oldest-first so the later value lands last.
         if (slot_addr_a[0] == slot_addr_a[1]) begin
            grant_v[age_q] = 1'b1;
         end else if (starve_cnt_q == STARVE_LIM) begin
            grant_v[1] = 1'b1;
         end else begin
            grant_v[0] = 1'b1;
         end
      end else if (full_v[0]) begin
         grant_v[0] = 1'b1;
      end else if (full_v[1]) begin
         grant_v[1] = 1'b1;
      end
   end

   always_comb begin
      age_d = age_q;
      if (fill_v[0] && keep_v[1]) begin
         age_d = 1'b1;
      end else if (fill_v[1] && keep_v[0]) begin
         age_d = 1'b0;
      end else if (fill_v[0] && fill_v[1]) begin
         age_d = 1'b0;
      end

      starve_cnt_d = starve_cnt_q;
      if (grant_v[1]) begin
         starve_cnt_d = '0;
      end else if (full_v[1] && starve_cnt_q != STARVE_LIM) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end

      regwrite_d = |grant_v;
      wr_d       = wr_q;
      wd_d       = wd_q;
      if (grant_v[1]) begin
         wr_d = slot_addr_a[1];
         wd_d = slot_data_a[1];
      end else if (grant_v[0]) begin
         wr_d = slot_addr_a[0];
         wd_d = slot_data_a[0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         age_q        <= 1'b0;
         starve_cnt_q <= '0;
         regwrite_q   <= 1'b0;
         wr_q         <= '0;
         wd_q         <= '0;
      end else begin
         age_q        <= age_d;
         starve_cnt_q <= starve_cnt_d;
         regwrite_q   <= regwrite_d;
         wr_q         <= wr_d;
         wd_q         <= wd_d;
      end
   end

   assign regwrite = regwrite_q;
   assign wr       = wr_q;
   assign wd       = wd_q;
   assign busy     = |full_v || regwrite_q;

`ifdef REGFILE_ARB_FWD_EN
   logic [ADDR_W-1:0] rr_a [2];
   logic [DATA_W-1:0] rd_in_a [2];
   logic [DATA_W-1:0] rd_a [2];
   logic              old_idx, yng_idx;

   assign rr_a[0]    = rr1;
   assign rr_a[1]    = rr2;
   assign rd_in_a[0] = rd1_in;
   assign rd_in_a[1] = rd2_in;
   assign old_idx    = age_q;
   assign yng_idx    = !age_q;
   assign rd1        = rd_a[0];
   assign rd2        = rd_a[1];

   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         logic [DATA_W-1:0] fwd;

         // Later assignments override earlier ones: newest pending value wins.
         always_comb begin
            fwd = rd_in_a[gi];
            if (regwrite_q && wr_q == rr_a[gi]) begin
               fwd = wd_q;
            end
            if (full_v[old_idx] && slot_addr_a[old_idx] == rr_a[gi]) begin
               fwd = slot_data_a[old_idx];
            end
            if (full_v[yng_idx] && slot_addr_a[yng_idx] == rr_a[gi]) begin
               fwd = slot_data_a[yng_idx];
            end
         end

         assign rd_a[gi] = fwd;
      end
   endgenerate
`else
   logic unused_rr;

   assign rd1       = rd1_in;
   assign rd2       = rd2_in;
   assign unused_rr = ^{rr1, rr2};
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a behavioural 4x16 register file on the write port.
// Expectations adapt to REGFILE_ARB_FWD_EN when the bench is built with that macro.
module tb_regfile_wr_arbiter;
   import regfile_pkg::*;

   logic              clock = 1'b0;
   logic              reset;
   logic              req0_valid, req0_ready, req1_valid, req1_ready;
   logic [ADDR_W-1:0] req0_addr, req1_addr, wr, rr1, rr2;
   logic [DATA_W-1:0] req0_data, req1_data, wd, rd1_in, rd2_in, rd1, rd2;
   logic              regwrite, busy;

   logic [DATA_W-1:0] rf [NUM_REGS] = '{default: '0};
   logic [ADDR_W-1:0] wlog_addr [$];
   logic [DATA_W-1:0] wlog_data [$];
   int                acc0, acc1;
   int                checks = 0;
   int                errors = 0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (regwrite) rf[wr] <= wd;
   end

   assign rd1_in = rf[rr1];
   assign rd2_in = rf[rr2];

   regfile_wr_arbiter #(.STARVE_MAX(3)) dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .wr         (wr),
      .wd         (wd),
      .regwrite   (regwrite),
      .rr1        (rr1),
      .rr2        (rr2),
      .rd1_in     (rd1_in),
      .rd2_in     (rd2_in),
      .rd1        (rd1),
      .rd2        (rd2),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   // Advance one edge, then log handshakes and any write the DUT presents.
   task automatic tick();
      logic f0, f1;
      f0 = req0_valid && req0_ready;
      f1 = req1_valid && req1_ready;
      @(posedge clock);
      #1;
      if (f0) acc0++;
      if (f1) acc1++;
      if (regwrite) begin
         wlog_addr.push_back(wr);
         wlog_data.push_back(wd);
      end
   endtask

   initial begin
      reset      = 1'b1;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      rr1 = '0; rr2 = '0;
      acc0 = 0; acc1 = 0;

      // reset held two cycles with a write offered
      #1;
      req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 16'd123;
      tick(); tick();
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_regwrite", regwrite, 0);
      check("rst_wr", wr, 0);
      check("rst_wd", wd, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0; req0_valid = 1'b0;
      tick(); tick();
      check("rst_nowrite_r1", rf[1], 0);
      check("rst_nowrite_log", wlog_addr.size(), 0);

      // single write latency
      req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 16'd500;
      check("lat_ready0", req0_ready, 1);
      tick();
      req0_valid = 1'b0; rr1 = 2'd1;
      check("lat_regwrite_k", regwrite, 0);
      check("lat_busy_k", busy, 1);
`ifdef REGFILE_ARB_FWD_EN
      check("lat_rd1_fwd", rd1, 500);
`else
      check("lat_rd1_pass", rd1, 0);
`endif
      tick();
      check("lat_regwrite", regwrite, 1);
      check("lat_wr", wr, 1);
      check("lat_wd", wd, 500);
      tick();
      check("lat_rf1", rf[1], 500);
      check("lat_regwrite_off", regwrite, 0);
      check("lat_busy_off", busy, 0);
      check("lat_rd1", rd1, 500);

      // both requesters streaming: req1 wins one write in four
      wlog_addr.delete(); wlog_data.delete();
      acc0 = 0; acc1 = 0;
      req0_valid = 1'b1; req0_addr = 2'd2; req0_data = 16'd100;
      req1_valid = 1'b1; req1_addr = 2'd3; req1_data = 16'd200;
      for (int c = 0; c < 13; c++) begin
         logic f0, f1;
         f0 = req0_valid && req0_ready;
         f1 = req1_valid && req1_ready;
         tick();
         if (f0) req0_data++;
         if (f1) req1_data++;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("strm_writes", wlog_addr.size(), 12);
      for (int n = 0; n < 12; n++) begin
         if (n % 4 == 3) begin
            check($sformatf("strm_addr%0d", n), wlog_addr[n], 3);
            check($sformatf("strm_data%0d", n), wlog_data[n], 200 + n / 4);
         end else begin
            check($sformatf("strm_addr%0d", n), wlog_addr[n], 2);
            check($sformatf("strm_data%0d", n), wlog_data[n], 100 + n - (n + 1) / 4);
         end
      end
      tick(); tick(); tick();
      check("strm_acc0", acc0, 10);
      check("strm_acc1", acc1, 4);
      check("strm_noloss", wlog_addr.size(), 14);
      check("strm_tail12", {wlog_addr[12], wlog_data[12]}, {2'd2, 16'd109});
      check("strm_tail13", {wlog_addr[13], wlog_data[13]}, {2'd3, 16'd203});

      // same address, req1 then req0 on consecutive edges
      req1_valid = 1'b1; req1_addr = 2'd3; req1_data = 16'd7;
      tick();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_addr = 2'd3; req0_data = 16'd9;
      tick();
      req0_valid = 1'b0;
      check("ord_regwrite", regwrite, 1);
      check("ord_wr_a", wr, 3);
      check("ord_wd_a", wd, 7);
      tick();
      check("ord_wr_b", wr, 3);
      check("ord_wd_b", wd, 9);
      tick();
      check("ord_rf3", rf[3], 9);

      // both full on one address: older slot1 must go before newer slot0
      req0_valid = 1'b1; req0_addr = 2'd2; req0_data = 16'd11;
      req1_valid = 1'b1; req1_addr = 2'd3; req1_data = 16'd22;
      tick();
      req1_valid = 1'b0;
      req0_addr = 2'd3; req0_data = 16'd33;
      check("age_ready0", req0_ready, 1);
      tick();
      req0_valid = 1'b0; rr2 = 2'd3;
      check("age_wd0", wd, 11);
`ifdef REGFILE_ARB_FWD_EN
      check("age_rd2_fwd", rd2, 33);
`else
      check("age_rd2_pass", rd2, 9);
`endif
      tick();
      check("age_wr1", wr, 3);
      check("age_wd1", wd, 22);
      tick();
      check("age_wd2", wd, 33);
      tick();
      check("age_rf3", rf[3], 33);

      // read forwarding of a pending req1 write
      rr1 = 2'd2;
      req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 16'd30000;
      tick();
      req1_valid = 1'b0;
`ifdef REGFILE_ARB_FWD_EN
      check("fwd_rd1_slot", rd1, 30000);
`else
      check("fwd_rd1_pass", rd1, 11);
`endif
      tick();
      check("fwd_wd", wd, 30000);
`ifdef REGFILE_ARB_FWD_EN
      check("fwd_rd1_oreg", rd1, 30000);
`else
      check("fwd_rd1_pass2", rd1, 11);
`endif
      tick();
      check("fwd_rf2", rf[2], 30000);
      check("fwd_rd1_rf", rd1, 30000);

      // reset with both slots full drops the pending writes
      req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 16'd1111;
      req1_valid = 1'b1; req1_addr = 2'd1; req1_data = 16'd2222;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("mrst_busy_before", busy, 1);
      wlog_addr.delete(); wlog_data.delete();
      reset = 1'b1;
      tick();
      check("mrst_regwrite", regwrite, 0);
      check("mrst_busy", busy, 0);
      check("mrst_ready0", req0_ready, 0);
      reset = 1'b0;
      tick(); tick(); tick();
      check("mrst_log", wlog_addr.size(), 0);
      check("mrst_rf0", rf[0], 0);
      check("mrst_rf1", rf[1], 500);

      // address 0 is an ordinary register
      req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 16'hFFFF;
      tick();
      req0_valid = 1'b0;
      tick(); tick();
      check("addr0_rf0", rf[0], 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
